// File: rtl/pipe_pkg.sv
// pipe_pkg: state encoding and shared constants for pipeline stage registers.
package pipe_pkg;

    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} pipe_state_t;

    // Wide enough for any stage's control field; stages take the low CTRL_W bits.
    localparam logic [255:0] NOP_CTRL = '0;

endpackage

// File: rtl/pipe_sat_counter.sv
// pipe_sat_counter: counter that sticks at all-ones; cleared only by reset.
module pipe_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt_q <= '0;
        else if (inc && !(&cnt_q))
            cnt_q <= cnt_q + CNT_W'(1);
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: valid/ready pipeline register with 2-entry skid buffer and flush.
// Define PIPE_STAGE_STATS_EN to add the stall_cnt/kill_cnt statistics ports.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl
`ifdef PIPE_STAGE_STATS_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  kill_cnt
`endif
);

    pipe_state_t       state_q, state_d;
    logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
    logic              in_fire, out_fire;

    // Ready depends only on registered state, so out_ready never reaches in_ready.
    assign in_ready  = state_q != FULL;
    assign out_valid = state_q != EMPTY;
    assign out_data  = main_data_q;
    assign out_ctrl  = main_ctrl_q;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;
        if (flush) begin
            state_d     = EMPTY;
            main_data_d = '0;
            main_ctrl_d = NOP_CTRL[CTRL_W-1:0];
            skid_data_d = '0;
            skid_ctrl_d = NOP_CTRL[CTRL_W-1:0];
        end else begin
            case (state_q)
                EMPTY: if (in_fire) begin
                    state_d     = ONE;
                    main_data_d = in_data;
                    main_ctrl_d = in_ctrl;
                end
                ONE: if (in_fire && out_fire) begin
                    main_data_d = in_data;
                    main_ctrl_d = in_ctrl;
                end else if (in_fire) begin
                    state_d     = FULL;
                    skid_data_d = in_data;
                    skid_ctrl_d = in_ctrl;
                end else if (out_fire) begin
                    state_d     = EMPTY;
                    main_data_d = '0;
                    main_ctrl_d = NOP_CTRL[CTRL_W-1:0];
                end
                FULL: if (out_ready) begin
                    state_d     = ONE;
                    main_data_d = skid_data_q;
                    main_ctrl_d = skid_ctrl_q;
                    skid_data_d = '0;
                    skid_ctrl_d = NOP_CTRL[CTRL_W-1:0];
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= EMPTY;
            main_data_q <= '0;
            main_ctrl_q <= '0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_ctrl_q <= main_ctrl_d;
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
        end
    end

    hold_stable_a: assert property (@(posedge clk) disable iff (reset)
        (out_valid && !out_ready && !flush) |=> ($stable(out_data) && $stable(out_ctrl)));

`ifdef PIPE_STAGE_STATS_EN
    logic stall_inc, kill_inc;

    // A flush kills something if a held entry is not leaving, the skid is full, or an input is accepted.
    assign stall_inc = out_valid && !out_ready;
    assign kill_inc  = flush && (stall_inc || state_q == FULL || in_fire);

    pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk(clk), .reset(reset), .inc(stall_inc), .cnt(stall_cnt)
    );
    pipe_sat_counter #(.CNT_W(CNT_W)) u_kill_cnt (
        .clk(clk), .reset(reset), .inc(kill_inc), .cnt(kill_cnt)
    );
`endif

endmodule
